// File: rtl/attribute_scanner_pkg.sv
// Shared widths, character constants and scanner state encoding.
package attribute_scanner_pkg;

    localparam int unsigned CHAR_BITES          = 8;
    localparam int unsigned ATTRIBUTE_VAL_BITES = 16;

    localparam logic [CHAR_BITES-1:0] CH_SPACE   = 8'h20;
    localparam logic [CHAR_BITES-1:0] CH_EQ      = 8'h3D;
    localparam logic [CHAR_BITES-1:0] CH_CLOSE   = 8'h3E;
    localparam logic [CHAR_BITES-1:0] CH_DIGIT_0 = 8'h30;
    localparam logic [CHAR_BITES-1:0] CH_DIGIT_9 = 8'h39;
    localparam logic [CHAR_BITES-1:0] CH_LOWER_A = 8'h61;
    localparam logic [CHAR_BITES-1:0] CH_LOWER_Z = 8'h7A;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRIME    = 3'd1,
        S_NAME     = 3'd2,
        S_EQUALS   = 3'd3,
        S_VALUE    = 3'd4,
        S_WAIT_FIN = 3'd5,
        S_DONE     = 3'd6,
        S_ERROR    = 3'd7
    } scan_state_e;

endpackage

// File: rtl/attr_char_class.sv
// Combinational classifier for the attribute grammar alphabet.
module attr_char_class
    import attribute_scanner_pkg::*;
(
    input  logic [CHAR_BITES-1:0] ch,
    output logic                  is_letter,
    output logic                  is_digit,
    output logic                  is_space,
    output logic                  is_eq,
    output logic                  is_close
);

    assign is_letter = (ch >= CH_LOWER_A) && (ch <= CH_LOWER_Z);
    assign is_digit  = (ch >= CH_DIGIT_0) && (ch <= CH_DIGIT_9);
    assign is_space  = (ch == CH_SPACE);
    assign is_eq     = (ch == CH_EQ);
    assign is_close  = (ch == CH_CLOSE);

endmodule

// File: rtl/attribute_scanner.sv
// Walks "name=digits " attributes of one tag from the document ROM, drives
// integer_parser and emits one (name, value) write per completed attribute.
module attribute_scanner
    import attribute_scanner_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_ATTRS = 8,
    parameter int unsigned MAX_LEN   = 255
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              start_addr,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [CHAR_BITES-1:0]          rom_data,
    output logic [CHAR_BITES-1:0]          char,
    output logic                           int_enable,
    input  logic [ATTRIBUTE_VAL_BITES-1:0] int_value,
    input  logic                           int_finished,
    output logic [CHAR_BITES-1:0]          attr_name,
    output logic [ATTRIBUTE_VAL_BITES-1:0] attr_value,
    output logic                           attr_write,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [ADDR_W-1:0]              end_addr
);

    localparam int unsigned CNT_W = $clog2(MAX_ATTRS + 1);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    scan_state_e                    state_q, state_d;
    logic [ADDR_W-1:0]              rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]              end_addr_q, end_addr_d;
    logic [CHAR_BITES-1:0]          attr_name_q, attr_name_d;
    logic [ATTRIBUTE_VAL_BITES-1:0] attr_value_q, attr_value_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic                           attr_write_q, attr_write_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;
    logic                           int_enable_q, int_enable_d;

    logic              is_letter, is_digit, is_space, is_eq, is_close;
    logic              len_over;
    logic [ADDR_W-1:0] char_addr;

    // Classify the character currently presented by the ROM.
    attr_char_class u_class (
        .ch        (rom_data),
        .is_letter (is_letter),
        .is_digit  (is_digit),
        .is_space  (is_space),
        .is_eq     (is_eq),
        .is_close  (is_close)
    );

    // rom_addr runs one ahead of the presented char in every consuming state.
    assign char_addr = rom_addr_q - ADDR_W'(1);
    assign len_over  = (len_q == LEN_W'(MAX_LEN));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        end_addr_d   = end_addr_q;
        attr_name_d  = attr_name_q;
        attr_value_d = attr_value_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        busy_d       = busy_q;
        attr_write_d = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;

        if (done_q || error_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    state_d    = S_PRIME;
                    rom_addr_d = start_addr;
                    cnt_d      = '0;
                    len_d      = '0;
                    busy_d     = 1'b1;
                end
            end
            S_PRIME: begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = S_NAME;
            end
            S_NAME: begin
                if (len_over) begin
                    state_d    = S_ERROR;
                    end_addr_d = char_addr;
                end else begin
                    len_d      = len_q + LEN_W'(1);
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    if (is_letter) begin
                        attr_name_d = rom_data;
                        state_d     = S_EQUALS;
                    end else if (is_close) begin
                        state_d    = S_DONE;
                        end_addr_d = char_addr;
                    end else if (!is_space) begin
                        state_d    = S_ERROR;
                        end_addr_d = char_addr;
                    end
                end
            end
            S_EQUALS: begin
                if (len_over || !is_eq) begin
                    state_d    = S_ERROR;
                    end_addr_d = char_addr;
                end else begin
                    len_d      = len_q + LEN_W'(1);
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = S_VALUE;
                end
            end
            S_VALUE: begin
                if (len_over || !(is_digit || is_space)) begin
                    state_d    = S_ERROR;
                    end_addr_d = char_addr;
                end else begin
                    len_d = len_q + LEN_W'(1);
                    if (is_digit) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                    end else begin
                        // Hold so the char after the space is re-fetched for NAME.
                        state_d = S_WAIT_FIN;
                    end
                end
            end
            S_WAIT_FIN: begin
                // Restore the one-ahead lookahead lost by the hold in VALUE.
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                if (!int_finished || (cnt_q == CNT_W'(MAX_ATTRS))) begin
                    state_d    = S_ERROR;
                    end_addr_d = char_addr;
                end else begin
                    attr_value_d = int_value;
                    attr_write_d = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    state_d      = S_NAME;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        int_enable_d = (state_d == S_VALUE) || (state_d == S_WAIT_FIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            end_addr_q   <= '0;
            attr_name_q  <= '0;
            attr_value_q <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            attr_write_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            int_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            end_addr_q   <= end_addr_d;
            attr_name_q  <= attr_name_d;
            attr_value_q <= attr_value_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            attr_write_q <= attr_write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            int_enable_q <= int_enable_d;
        end
    end

    assign char       = rom_data;
    assign rom_addr   = rom_addr_q;
    assign end_addr   = end_addr_q;
    assign attr_name  = attr_name_q;
    assign attr_value = attr_value_q;
    assign attr_write = attr_write_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign int_enable = int_enable_q;

endmodule

// File: tb/tb_attribute_scanner.sv
// Directed bench: ROM model, integer_parser stand-in, event log and checks.
module tb_attribute_scanner;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] start_addr;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  char_w;
    logic        int_enable;
    logic [15:0] int_value;
    logic        int_fin_m;
    logic        park_fin;
    logic [7:0]  attr_name;
    logic [15:0] attr_value;
    logic        attr_write;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] end_addr;

    logic [7:0]  mem [0:1023];

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t0    = 0;

    logic [7:0]  wr_name [$];
    logic [15:0] wr_val  [$];
    int          wr_cyc  [$];
    int          n_done  = 0;
    int          n_err   = 0;
    int          done_cyc = 0;
    int          err_cyc  = 0;

    attribute_scanner dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .char         (char_w),
        .int_enable   (int_enable),
        .int_value    (int_value),
        .int_finished (int_fin_m & ~park_fin),
        .attr_name    (attr_name),
        .attr_value   (attr_value),
        .attr_write   (attr_write),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .end_addr     (end_addr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous document ROM: data returns the cycle after the address.
    always @(posedge clock) rom_data <= mem[rom_addr[9:0]];

    // integer_parser stand-in: accumulates decimal digits while enabled,
    // finishes on the first non-digit, clears whenever enable is low.
    always @(posedge clock) begin
        if (reset || !int_enable) begin
            int_value <= 16'd0;
            int_fin_m <= 1'b0;
        end else if (!int_fin_m) begin
            if (char_w >= 8'h30 && char_w <= 8'h39)
                int_value <= int_value * 16'd10 + 16'(char_w - 8'h30);
            else
                int_fin_m <= 1'b1;
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Event log sampled just after each active edge.
    always @(posedge clock) begin
        #1;
        if (attr_write) begin
            wr_name.push_back(attr_name);
            wr_val.push_back(attr_value);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (error) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_tag(input int a, input string s);
        for (int i = 0; i < s.len(); i++) mem[10'(a + i)] = s[i];
    endtask

    task automatic clear_log();
        wr_name.delete();
        wr_val.delete();
        wr_cyc.delete();
        n_done   = 0;
        n_err    = 0;
        done_cyc = 0;
        err_cyc  = 0;
    endtask

    // Pulse start for one edge; t0 is the accepting edge, returns at its negedge.
    task automatic kick(input logic [15:0] a);
        @(negedge clock);
        clear_log();
        start      = 1'b1;
        start_addr = a;
        t0         = cyc + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while ((n_done + n_err) == 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("ended", 32'(n_done + n_err), 32'd1);
    endtask

    task automatic chk_write(input string tag, input int idx, input logic [7:0] nm,
                             input logic [15:0] val);
        check({tag, "_present"}, 32'(wr_name.size() > idx), 32'd1);
        if (wr_name.size() > idx) begin
            check({tag, "_name"}, 32'(wr_name[idx]), 32'(nm));
            check({tag, "_value"}, 32'(wr_val[idx]), 32'(val));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_flags"}, 32'({attr_write, busy, done, error, int_enable}), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_name"}, 32'(attr_name), 32'd0);
        check({tag, "_value"}, 32'(attr_value), 32'd0);
        check({tag, "_end_addr"}, 32'(end_addr), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = 16'h0;
        park_fin   = 1'b0;

        load_tag(16'h010, "a=5 >");
        load_tag(16'h040, "x=120 y=7 >");
        load_tag(16'h060, "b=12>");
        for (int k = 0; k < 9; k++) begin
            mem[10'(16'h080 + 4 * k)]     = 8'(8'h61 + k);
            mem[10'(16'h080 + 4 * k + 1)] = 8'h3D;
            mem[10'(16'h080 + 4 * k + 2)] = 8'h31;
            mem[10'(16'h080 + 4 * k + 3)] = 8'h20;
        end
        mem[10'(16'h080 + 36)] = 8'h3E;
        load_tag(16'h0C0, "c=99 >");
        load_tag(16'h0E0, "a= >");
        for (int i = 0; i < 254; i++) mem[10'(16'h100 + i)] = 8'h20;
        mem[10'h1FE] = 8'h3E;
        for (int i = 0; i < 255; i++) mem[10'(16'h200 + i)] = 8'h20;
        mem[10'h2FF] = 8'h3E;

        repeat (3) @(negedge clock);
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Single attribute with exact pulse timing.
        kick(16'h010);
        check("t1_busy_up", 32'(busy), 32'd1);
        wait_end(40);
        check("t1_nwrites", 32'(wr_name.size()), 32'd1);
        chk_write("t1_w0", 0, 8'h61, 16'd5);
        if (wr_cyc.size() > 0) check("t1_write_cyc", 32'(wr_cyc[0] - t0), 32'd6);
        check("t1_done_cyc", 32'(done_cyc - t0), 32'd8);
        check("t1_nerr", 32'(n_err), 32'd0);
        check("t1_end_addr", 32'(end_addr), 32'h14);
        check("t1_busy_hold", 32'(busy), 32'd1);
        @(negedge clock);
        check("t1_busy_drop", 32'(busy), 32'd0);

        // Two attributes, multi-digit value.
        kick(16'h040);
        wait_end(60);
        check("t2_nwrites", 32'(wr_name.size()), 32'd2);
        chk_write("t2_w0", 0, 8'h78, 16'd120);
        chk_write("t2_w1", 1, 8'h79, 16'd7);
        if (wr_cyc.size() > 1) check("t2_write1_cyc", 32'(wr_cyc[1] - t0), 32'd13);
        check("t2_done_cyc", 32'(done_cyc - t0), 32'd15);
        check("t2_nerr", 32'(n_err), 32'd0);
        check("t2_end_addr", 32'(end_addr), 32'h4A);
        repeat (2) @(negedge clock);

        // Missing space before '>'.
        kick(16'h060);
        wait_end(40);
        check("t3_nerr", 32'(n_err), 32'd1);
        check("t3_ndone", 32'(n_done), 32'd0);
        check("t3_nwrites", 32'(wr_name.size()), 32'd0);
        check("t3_err_cyc", 32'(err_cyc - t0), 32'd7);
        check("t3_end_addr", 32'(end_addr), 32'h64);
        repeat (2) @(negedge clock);

        // Nine attributes: eighth is the last allowed write.
        kick(16'h080);
        wait_end(100);
        check("t4_nwrites", 32'(wr_name.size()), 32'd8);
        chk_write("t4_w7", 7, 8'h68, 16'd1);
        check("t4_nerr", 32'(n_err), 32'd0 + 32'd1);
        check("t4_ndone", 32'(n_done), 32'd0);
        check("t4_end_addr", 32'(end_addr), 32'hA3);
        repeat (2) @(negedge clock);

        // Reset during VALUE aborts silently; rescan afterwards is clean.
        kick(16'h0C0);
        repeat (4) @(negedge clock);
        check("t5_in_value", 32'(int_enable), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_idle_outputs("t5_after_reset");
        repeat (12) @(negedge clock);
        check("t5_no_events", 32'(n_done + n_err + wr_name.size()), 32'd0);
        kick(16'h0C0);
        wait_end(40);
        chk_write("t5_w0", 0, 8'h63, 16'd99);
        check("t5_ndone", 32'(n_done), 32'd1);
        check("t5_end_addr", 32'(end_addr), 32'hC5);
        repeat (2) @(negedge clock);

        // Reset on the same edge as start wins.
        @(negedge clock);
        clear_log();
        reset = 1'b1;
        start = 1'b1;
        start_addr = 16'h010;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        check("t6_rst_start_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clock);
        check("t6_rst_start_quiet", 32'(n_done + n_err + wr_name.size()), 32'd0);

        // Empty value, plus start pulses while busy that must be ignored.
        kick(16'h0E0);
        start = 1'b1;
        start_addr = 16'h060;
        @(negedge clock);
        start = 1'b0;
        wait_end(40);
        check("t7_nwrites", 32'(wr_name.size()), 32'd1);
        chk_write("t7_w0", 0, 8'h61, 16'd0);
        check("t7_done_cyc", 32'(done_cyc - t0), 32'd7);
        check("t7_end_addr", 32'(end_addr), 32'hE3);
        start = 1'b1;
        start_addr = 16'h060;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        check("t7_ignored_err", 32'(n_err), 32'd0);
        check("t7_ignored_done", 32'(n_done), 32'd1);

        // integer_parser never finishing times out in WAIT_FIN.
        park_fin = 1'b1;
        kick(16'h010);
        wait_end(40);
        park_fin = 1'b0;
        check("t8_nerr", 32'(n_err), 32'd1);
        check("t8_nwrites", 32'(wr_name.size()), 32'd0);
        check("t8_err_cyc", 32'(err_cyc - t0), 32'd7);
        check("t8_end_addr", 32'(end_addr), 32'h13);
        repeat (2) @(negedge clock);

        // Length limit: 255 chars close cleanly, the 256th is an error.
        kick(16'h100);
        wait_end(300);
        check("t9_ndone", 32'(n_done), 32'd1);
        check("t9_end_addr", 32'(end_addr), 32'h1FE);
        repeat (2) @(negedge clock);
        kick(16'h200);
        wait_end(300);
        check("t10_nerr", 32'(n_err), 32'd1);
        check("t10_end_addr", 32'(end_addr), 32'h2FF);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
